riscv_divider: RTL and testbench
================================

Name: riscv_divider

Overview:
- Multi-cycle restoring divider for the RV32M divide group: DIV, DIVU, REM, REMU.
- Performs division as the inverse of addition: one trial subtraction per cycle, restoring on negative result.
- Sits beside the ALU in the execute stage.
- Handshakes operands in with valid/ready and holds the result with valid/ready until the pipeline consumes it.

Parameters:
- XLEN, 32, operand and result width in bits; must be ≥ 4.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
- in_valid  input  1  operands and op are valid.
- in_ready  output  1  divider can accept a new operation.
- op  input  2  operation: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
- dividend  input  XLEN  rs1 value.
- divisor  input  XLEN  rs2 value.
- out_valid  output  1  result is valid.
- out_ready  input  1  consumer accepts the result.
- result  output  XLEN  quotient (DIV/DIVU) or remainder (REM/REMU).

Behaviour:
- Reset (rst=1 at a clk edge):
  - state := IDLE; in_ready=1, out_valid=0, result=0; internal registers cleared.
  - Reset mid-operation aborts the operation; no result is ever produced for it.
- States: IDLE, PREP, CALC, FIX, DONE.
  - in_ready = (state==IDLE).
  - out_valid = (state==DONE).
- IDLE:
  - On in_valid&&in_ready at edge T, capture op, dividend and divisor; go to PREP.
- PREP (T+1):
  - signed = ~op[0].
  - For signed ops, take absolute values; record q_neg = sign(dividend)^sign(divisor) and r_neg = sign(dividend).
  - Special cases go directly to DONE with the result loaded:
    - divisor==0: quotient = all ones; remainder = original dividend.
    - Signed overflow (dividend == most-negative value and divisor == -1): quotient = most-negative value; remainder = 0.
  - Otherwise clear the XLEN+1-bit partial remainder, load the quotient shift register with |dividend|, set count = XLEN-1, and go to CALC.
- CALC (XLEN cycles, T+2 .. T+XLEN+1):
  - Each cycle, shift {rem, quo} left by 1 and trial-subtract |divisor| from rem.
  - If the difference is non-negative, rem := difference and the quotient LSB := 1; otherwise restore rem and set the LSB to 0.
  - When count==0, go to FIX; else count--.
- FIX (T+XLEN+2):
  - Apply sign: quotient negated if q_neg, remainder negated if r_neg (signed ops only).
  - Select quotient or remainder per op[1]; register into result; go to DONE.
- DONE:
  - out_valid=1 from T+XLEN+3 (normal path) or T+2 (special case).
  - result is held stable while out_valid && !out_ready.
  - On out_valid && out_ready, go to IDLE next cycle.
  - in_ready rises the cycle after the result is accepted; no same-cycle result-out/operand-in overlap.
- Remainder sign always follows the dividend; |remainder| < |divisor|.
- in_valid while busy is ignored. Operand inputs are not sampled outside the accept edge.
- Zero dividend is not special-cased: it takes the normal path and yields 0.

Test Plan:
- DIVU 100/7 → after accept, out_valid exactly XLEN+3 cycles later (35 for XLEN=32); result = 14. REMU on the same operands → 2.
- DIV -7/2 → 0xFFFFFFFD (-3). REM -7/2 → 0xFFFFFFFF (-1). DIV 7/-2 → -3. REM 7/-2 → 1.
- Divide by zero: DIVU 5/0 → 0xFFFFFFFF; DIV -5/0 → 0xFFFFFFFF; REM -5/0 → 0xFFFFFFFB. out_valid 2 cycles after accept.
- Overflow: DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM on the same operands → 0. Both take the 2-cycle path.
- Back-pressure: hold out_ready=0 for 10 cycles after out_valid. Result stable, in_ready=0, and new in_valid is ignored. Then raise out_ready → IDLE next cycle; a new op is accepted.
- Reset mid-CALC: assert rst at cycle 10 of CALC → next cycle in_ready=1, out_valid=0, result=0. A following DIVU 0xFFFFFFFF/1 → 0xFFFFFFFF.

Source files
------------

// File: rtl/riscv_divider.sv
`default_nettype none
// ============================================================================
//  Module   : riscv_divider
//  Brief    : Multi-cycle restoring divider for RV32M DIV/DIVU/REM/REMU.
//             One trial subtraction per cycle, valid/ready on both sides.
//  Revision : 1.0 - initial release
// ============================================================================
module riscv_divider #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result
);

    localparam int              c_CW       = $clog2(XLEN);
    localparam logic [c_CW-1:0] c_CNT_INIT = c_CW'(XLEN - 1);
    localparam logic [XLEN-1:0] c_MIN      = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PREP = 3'd1,
        S_CALC = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t            r_state;
    logic              r_in_ready;
    logic              r_out_valid;
    logic [XLEN-1:0]   r_result;
    logic [1:0]        r_op;
    logic [XLEN-1:0]   r_dvd;
    // Holds the raw divisor until PREP, then its magnitude for the CALC loop.
    logic [XLEN-1:0]   r_dvs;
    // The partial remainder is always below the divisor between iterations,
    // so only the shifted trial value needs the extra (XLEN+1) bit.
    logic [XLEN-1:0]   r_rem;
    logic [XLEN-1:0]   r_quo;
    logic [c_CW-1:0]   r_cnt;
    logic              r_q_neg;
    logic              r_r_neg;

    logic              w_signed;
    logic              w_a_neg;
    logic              w_b_neg;
    logic [XLEN-1:0]   w_abs_a;
    logic [XLEN-1:0]   w_abs_b;
    logic              w_div_zero;
    logic              w_ovf;
    logic [XLEN:0]     w_shift;
    logic [XLEN:0]     w_diff;
    logic [XLEN-1:0]   w_q_fix;
    logic [XLEN-1:0]   w_r_fix;

    // Operand conditioning, trial subtraction and final sign correction.
    always_comb begin
        w_signed   = ~r_op[0];
        w_a_neg    = w_signed & r_dvd[XLEN-1];
        w_b_neg    = w_signed & r_dvs[XLEN-1];
        w_abs_a    = w_a_neg ? -r_dvd : r_dvd;
        w_abs_b    = w_b_neg ? -r_dvs : r_dvs;
        w_div_zero = (r_dvs == '0);
        w_ovf      = w_signed && (r_dvd == c_MIN) && (r_dvs == '1);
        w_shift    = {r_rem, r_quo[XLEN-1]};
        w_diff     = w_shift - {1'b0, r_dvs};
        w_q_fix    = r_q_neg ? -r_quo : r_quo;
        w_r_fix    = r_r_neg ? -r_rem : r_rem;
    end

    // Divider sequencer with registered handshake outputs and result.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_op        <= '0;
            r_dvd       <= '0;
            r_dvs       <= '0;
            r_rem       <= '0;
            r_quo       <= '0;
            r_cnt       <= '0;
            r_q_neg     <= 1'b0;
            r_r_neg     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_op       <= op;
                        r_dvd      <= dividend;
                        r_dvs      <= divisor;
                        r_in_ready <= 1'b0;
                        r_state    <= S_PREP;
                    end
                end
                S_PREP: begin
                    if (w_div_zero) begin
                        r_result    <= r_op[1] ? r_dvd : '1;
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end else if (w_ovf) begin
                        r_result    <= r_op[1] ? '0 : c_MIN;
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end else begin
                        r_q_neg <= w_a_neg ^ w_b_neg;
                        r_r_neg <= w_a_neg;
                        r_rem   <= '0;
                        r_quo   <= w_abs_a;
                        r_dvs   <= w_abs_b;
                        r_cnt   <= c_CNT_INIT;
                        r_state <= S_CALC;
                    end
                end
                S_CALC: begin
                    // A borrow out of the top bit means the trial went negative.
                    if (!w_diff[XLEN]) begin
                        r_rem <= w_diff[XLEN-1:0];
                        r_quo <= {r_quo[XLEN-2:0], 1'b1};
                    end else begin
                        r_rem <= w_shift[XLEN-1:0];
                        r_quo <= {r_quo[XLEN-2:0], 1'b0};
                    end
                    if (r_cnt == '0) begin
                        r_state <= S_FIX;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_FIX: begin
                    r_result    <= r_op[1] ? w_r_fix : w_q_fix;
                    r_out_valid <= 1'b1;
                    r_state     <= S_DONE;
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign result    = r_result;

endmodule
`default_nettype wire

// File: tb/tb_riscv_divider.sv
`default_nettype none
// ============================================================================
//  Module   : tb_riscv_divider
//  Brief    : Self-checking bench for riscv_divider against an arithmetic
//             reference model (directed cases plus random operations).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_riscv_divider;

    localparam int XLEN = 32;
    localparam int LAT_NORMAL  = XLEN + 3;
    localparam int LAT_SPECIAL = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [1:0]      op;
    logic [XLEN-1:0] dividend;
    logic [XLEN-1:0] divisor;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;

    int n_vec  = 0;
    int n_fail = 0;

    riscv_divider #(.XLEN(XLEN)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .dividend  (dividend),
        .divisor   (divisor),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result)
    );

    always #5 clk = ~clk;

    // Reference: RISC-V division semantics from plain 64-bit arithmetic.
    function automatic logic [31:0] model(input logic [1:0] m_op,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
        longint sa, sb, q, r;
        if (b == 32'd0) return m_op[1] ? a : 32'hFFFF_FFFF;
        if (!m_op[0]) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end
        q = sa / sb;
        r = sa % sb;
        return m_op[1] ? r[31:0] : q[31:0];
    endfunction

    function automatic int model_lat(input logic [1:0] m_op,
                                     input logic [31:0] a,
                                     input logic [31:0] b);
        if (b == 32'd0) return LAT_SPECIAL;
        if (!m_op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return LAT_SPECIAL;
        return LAT_NORMAL;
    endfunction

    // Issues one operation, waits for the result, consumes it.
    // lat = edge index (counting the accept edge as 0) at which out_valid is seen.
    task automatic run_op(input logic [1:0] t_op, input logic [31:0] a,
                          input logic [31:0] b, output logic [31:0] res,
                          output int lat);
        int n;
        int guard;
        res = 'x;
        lat = -1;
        @(negedge clk);
        in_valid = 1'b1; op = t_op; dividend = a; divisor = b; out_ready = 1'b0;
        guard = 0;
        while (!in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) begin
            n_vec++; n_fail++;
            $display("FAIL accept_timeout: in_ready=%0b required 1", in_ready);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        n = 0;
        forever begin
            @(negedge clk);
            if (n == 0) begin
                in_valid = 1'b0;
                dividend = $urandom;
                divisor  = $urandom;
                op       = 2'($urandom);
            end
            if (out_valid) break;
            if (n > 100) break;
            @(posedge clk);
            n++;
        end
        if (!out_valid) begin
            n_vec++; n_fail++;
            $display("FAIL result_timeout: out_valid=%0b required 1", out_valid);
            return;
        end
        lat = n + 1;
        res = result;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        op = '0; dividend = '0; divisor = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        n_vec++;
        if (in_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_in_ready: got %0b want 1", in_ready);
        end
        n_vec++;
        if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_out_valid: got %0b want 0", out_valid);
        end
        n_vec++;
        if (result !== 32'd0) begin
            n_fail++; $display("FAIL reset_result: got %h want 0", result);
        end
    endtask

    task automatic test_directed();
        logic [1:0]  d_op  [8] = '{2'b01, 2'b11, 2'b00, 2'b10, 2'b00, 2'b10, 2'b00, 2'b00};
        logic [31:0] d_a   [8] = '{32'd100, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF9,
                                   32'd7, 32'd7, 32'd0, 32'hFFFF_FF9C};
        logic [31:0] d_b   [8] = '{32'd7, 32'd7, 32'd2, 32'd2,
                                   32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'd9, 32'hFFFF_FFF6};
        logic [31:0] d_exp [8] = '{32'd14, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF,
                                   32'hFFFF_FFFD, 32'd1, 32'd0, 32'd10};
        logic [31:0] res;
        int lat;
        for (int i = 0; i < 8; i++) begin
            run_op(d_op[i], d_a[i], d_b[i], res, lat);
            n_vec++;
            if (res !== d_exp[i]) begin
                n_fail++;
                $display("FAIL directed_%0d result: got %h want %h", i, res, d_exp[i]);
            end
            n_vec++;
            if (lat != LAT_NORMAL) begin
                n_fail++;
                $display("FAIL directed_%0d latency: got %0d want %0d", i, lat, LAT_NORMAL);
            end
        end
    endtask

    task automatic test_special();
        logic [1:0]  s_op  [5] = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b10};
        logic [31:0] s_a   [5] = '{32'd5, 32'hFFFF_FFFB, 32'hFFFF_FFFB, 32'h8000_0000, 32'h8000_0000};
        logic [31:0] s_b   [5] = '{32'd0, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] s_exp [5] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 32'h8000_0000, 32'd0};
        logic [31:0] res;
        int lat;
        for (int i = 0; i < 5; i++) begin
            run_op(s_op[i], s_a[i], s_b[i], res, lat);
            n_vec++;
            if (res !== s_exp[i]) begin
                n_fail++;
                $display("FAIL special_%0d result: got %h want %h", i, res, s_exp[i]);
            end
            n_vec++;
            if (lat != LAT_SPECIAL) begin
                n_fail++;
                $display("FAIL special_%0d latency: got %0d want %0d", i, lat, LAT_SPECIAL);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] a, b, res, exp_r;
        logic [1:0]  r_op;
        int lat;
        for (int i = 0; i < 60; i++) begin
            r_op = 2'($urandom);
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 5))
                0: b = 32'($urandom_range(1, 20));
                1: b = 32'd0;
                2: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                3: a = 32'($urandom_range(0, 3));
                4: b = b >> $urandom_range(0, 31);
                default: ;
            endcase
            exp_r = model(r_op, a, b);
            run_op(r_op, a, b, res, lat);
            n_vec++;
            if (res !== exp_r) begin
                n_fail++;
                $display("FAIL random_%0d op=%0d a=%h b=%h: got %h want %h",
                         i, r_op, a, b, res, exp_r);
            end
            n_vec++;
            if (lat != model_lat(r_op, a, b)) begin
                n_fail++;
                $display("FAIL random_%0d latency: got %0d want %0d",
                         i, lat, model_lat(r_op, a, b));
            end
        end
    endtask

    task automatic test_back_pressure();
        logic [31:0] res;
        int lat;
        int guard;
        @(negedge clk);
        in_valid = 1'b1; op = 2'b01; dividend = 32'd1000; divisor = 32'd33; out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        guard = 0;
        while (!out_valid && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        n_vec++;
        if (!out_valid) begin
            n_fail++; $display("FAIL bp_out_valid: got %0b want 1", out_valid);
        end
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1; op = 2'b00; dividend = $urandom; divisor = $urandom;
            @(negedge clk);
            n_vec++;
            if (result !== 32'd30 || out_valid !== 1'b1 || in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_hold_%0d: result=%h out_valid=%0b in_ready=%0b want 1e/1/0",
                         i, result, out_valid, in_ready);
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        n_vec++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_release: in_ready=%0b out_valid=%0b want 1/0", in_ready, out_valid);
        end
        run_op(2'b11, 32'd1000, 32'd33, res, lat);
        n_vec++;
        if (res !== 32'd10) begin
            n_fail++; $display("FAIL bp_next_op: got %h want %h", res, 32'd10);
        end
    endtask

    task automatic test_reset_mid_calc();
        logic [31:0] res;
        int lat;
        logic seen;
        @(negedge clk);
        in_valid = 1'b1; op = 2'b01; dividend = 32'd123456; divisor = 32'd789; out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        // PREP occupies one edge; the tenth CALC edge is 11 edges after accept.
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        n_vec++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== 32'd0) begin
            n_fail++;
            $display("FAIL mid_reset: in_ready=%0b out_valid=%0b result=%h want 1/0/0",
                     in_ready, out_valid, result);
        end
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        out_ready = 1'b0;
        n_vec++;
        if (seen !== 1'b0) begin
            n_fail++; $display("FAIL mid_reset_abort: out_valid seen=%0b want 0", seen);
        end
        run_op(2'b01, 32'hFFFF_FFFF, 32'd1, res, lat);
        n_vec++;
        if (res !== 32'hFFFF_FFFF) begin
            n_fail++; $display("FAIL mid_reset_next: got %h want ffffffff", res);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_special();
        test_random();
        test_back_pressure();
        test_reset_mid_calc();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
